// File: rtl/cluster_pkg.sv
// Shared constants and types for the cluster unpacker slice.
package cluster_pkg;

    localparam int NUM_STRIPS       = 1536;
    localparam int ADR_W            = 11;
    localparam int CNT_W            = 3;
    localparam int RUN_W            = 1 << CNT_W;
    localparam int NCL_W            = 4;
    localparam int MAX_CLUSTERS_DEF = 8;

    localparam logic [ADR_W-1:0] EMPTY_ADR = 11'h7FE;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_FULL  = 1'b1
    } unpack_state_t;

endpackage

// File: rtl/cluster_expand.sv
// Combinational expansion of one {adr,cnt} cluster word into a strip mask.
// Bits past NUM_STRIPS-1 are shifted out of the vector, so long clusters at the top edge clip.
module cluster_expand
    import cluster_pkg::*;
(
    input  logic [ADR_W-1:0]      adr,
    input  logic [CNT_W-1:0]      cnt,
    output logic [NUM_STRIPS-1:0] mask,
    output logic                  in_range
);

    logic [RUN_W-1:0] run;

    assign run      = {RUN_W{1'b1}} >> (CNT_W'(RUN_W - 1) - cnt);
    assign mask     = {{(NUM_STRIPS - RUN_W){1'b0}}, run} << adr;
    assign in_range = (adr < ADR_W'(NUM_STRIPS));

endmodule

// File: rtl/cluster_unpacker.sv
// Rebuilds the S-bit hit map from a stream of cluster words, one map per bx frame.
// Define CLUSTER_UNPACKER_OVERLAP_CHK_EN to flag frames whose accepted clusters overlap.
module cluster_unpacker
    import cluster_pkg::*;
#(
    parameter int MAX_CLUSTERS = MAX_CLUSTERS_DEF
) (
    input  logic                  clock4x,
    input  logic                  global_reset_n,
    input  logic                  clst_valid,
    input  logic [ADR_W-1:0]      clst_adr,
    input  logic [CNT_W-1:0]      clst_cnt,
    input  logic                  bx_strobe,
    output logic [NUM_STRIPS-1:0] vpfs,
    output logic                  vpfs_valid,
    output logic [NCL_W-1:0]      nclusters,
    output logic                  overflow,
    output logic                  overlap_err
);

    unpack_state_t         state, state_next;
    logic [NUM_STRIPS-1:0] acc;
    logic [NUM_STRIPS-1:0] mask;
    logic [NUM_STRIPS-1:0] acc_next;
    logic [NCL_W-1:0]      count;
    logic [NCL_W-1:0]      count_next;
    logic                  in_range;
    logic                  accept;
    logic                  drop;
    logic                  ovf_flag;

    cluster_expand u_expand (
        .adr      (clst_adr),
        .cnt      (clst_cnt),
        .mask     (mask),
        .in_range (in_range)
    );

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) state <= ST_ACCUM;
        else                 state <= state_next;
    end

    // The frame fills up on the accepted word that brings the count to MAX_CLUSTERS.
    always_comb begin
        state_next = state;
        if (bx_strobe)
            state_next = ST_ACCUM;
        else if (state == ST_ACCUM && accept && count == NCL_W'(MAX_CLUSTERS - 1))
            state_next = ST_FULL;
    end

    always_comb begin
        accept = 1'b0;
        drop   = 1'b0;
        if (clst_valid && in_range) begin
            accept = (state == ST_ACCUM);
            drop   = (state == ST_FULL);
        end
    end

    assign acc_next   = acc | (accept ? mask : '0);
    assign count_next = count + NCL_W'(accept);

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            acc        <= '0;
            count      <= '0;
            ovf_flag   <= 1'b0;
            vpfs       <= '0;
            vpfs_valid <= 1'b0;
            nclusters  <= '0;
            overflow   <= 1'b0;
        end else if (bx_strobe) begin
            vpfs       <= acc_next;
            vpfs_valid <= 1'b1;
            nclusters  <= count_next;
            overflow   <= ovf_flag | drop;
            acc        <= '0;
            count      <= '0;
            ovf_flag   <= 1'b0;
        end else begin
            vpfs_valid <= 1'b0;
            acc        <= acc_next;
            count      <= count_next;
            ovf_flag   <= ovf_flag | drop;
        end
    end

`ifdef CLUSTER_UNPACKER_OVERLAP_CHK_EN
    logic ovl_flag;
    logic ovl_hit;

    assign ovl_hit = accept && (|(acc & mask));

    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            ovl_flag    <= 1'b0;
            overlap_err <= 1'b0;
        end else if (bx_strobe) begin
            overlap_err <= ovl_flag | ovl_hit;
            ovl_flag    <= 1'b0;
        end else begin
            ovl_flag    <= ovl_flag | ovl_hit;
        end
    end
`else
    assign overlap_err = 1'b0;
`endif

endmodule
